// File: rtl/uart_rx_frame_check.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_frame_check
// Frame checker for the UART receiver. Validates the start bit, shifts in
// DATA_WIDTH data bits LSB-first, checks optional even/odd parity and one or
// two stop bits, and delivers the word with per-frame error flags.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9)
//   STOP_BITS   stop bits per frame (1 or 2)
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_enable        block enable; low aborts to IDLE on the next edge
//   i_frame_start   line falling-edge pulse, honoured only in IDLE
//   i_sample_valid  mid-bit sample strobe
//   i_sampled_bit   sampled line value
//   i_par_en        parity bit present (latched at frame start)
//   i_par_type      0 = even, 1 = odd (latched at frame start)
//   o_data          last delivered word, held until next delivery
//   o_data_valid    one-cycle frame-complete pulse
//   o_parity_err    parity error of the delivered frame
//   o_stop_err      any stop bit of the delivered frame sampled 0
//   o_start_err     one-cycle pulse, start bit sampled 1 (frame discarded)
//   o_busy          high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_frame_check #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_frame_start,
    input  logic                  i_sample_valid,
    input  logic                  i_sampled_bit,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_parity_err,
    output logic                  o_stop_err,
    output logic                  o_start_err,
    output logic                  o_busy
);

    localparam int unsigned      CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q,      state_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic                  acc_q,        acc_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  stop_cnt_q,   stop_cnt_d;
    logic                  par_en_q,     par_en_d;
    logic                  par_type_q,   par_type_d;
    logic                  perr_q,       perr_d;
    logic                  serr_q,       serr_d;
    logic [DATA_WIDTH-1:0] data_q,       data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  stop_err_q,   stop_err_d;
    logic                  start_err_q,  start_err_d;
    logic                  busy_q,       busy_d;

    // State, datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            stop_cnt_q   <= 1'b0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            perr_q       <= 1'b0;
            serr_q       <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            start_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            par_en_q     <= par_en_d;
            par_type_q   <= par_type_d;
            perr_q       <= perr_d;
            serr_q       <= serr_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            stop_err_q   <= stop_err_d;
            start_err_q  <= start_err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        stop_cnt_d   = stop_cnt_q;
        par_en_d     = par_en_q;
        par_type_d   = par_type_q;
        perr_d       = perr_q;
        serr_d       = serr_q;
        data_d       = data_q;
        parity_err_d = parity_err_q;
        stop_err_d   = stop_err_q;
        data_valid_d = 1'b0;
        start_err_d  = 1'b0;

        if (!i_enable) begin
            // Abort: delivered outputs hold, no pulses
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Samples are ignored here, even alongside i_frame_start
                    if (i_frame_start) begin
                        state_d    = S_START;
                        par_en_d   = i_par_en;
                        par_type_d = i_par_type;
                        shift_d    = '0;
                        acc_d      = 1'b0;
                        cnt_d      = '0;
                        stop_cnt_d = 1'b0;
                        perr_d     = 1'b0;
                        serr_d     = 1'b0;
                    end
                end
                S_START: begin
                    if (i_sample_valid) begin
                        if (i_sampled_bit) begin
                            start_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (i_sample_valid) begin
                        shift_d = {i_sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        acc_d   = acc_q ^ i_sampled_bit;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (i_sample_valid) begin
                        perr_d  = (acc_q ^ i_sampled_bit) != par_type_q;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (i_sample_valid) begin
                        serr_d = serr_q | ~i_sampled_bit;
                        if (stop_cnt_q == STOP_LAST) begin
                            data_d       = shift_q;
                            parity_err_d = par_en_q & perr_q;
                            stop_err_d   = serr_d;
                            data_valid_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            stop_cnt_d = stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign o_data       = data_q;
    assign o_data_valid = data_valid_q;
    assign o_parity_err = parity_err_q;
    assign o_stop_err   = stop_err_q;
    assign o_start_err  = start_err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_check
// Two instances share the serial-side stimulus: A is 8 data / 1 stop,
// B is 7 data / 2 stop. Only the selected instance is enabled per frame.
// Expected words and flags come from frame-level arithmetic on the bit list.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_check;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic       frame_start, sample_valid, sampled_bit, par_en, par_type;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, perr_a, serr_a, start_err_a, busy_a;
    logic       valid_b, perr_b, serr_b, start_err_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    // Last delivered values per instance
    logic [8:0] exp_data [2];
    logic       exp_perr [2];
    logic       exp_serr [2];

    always #5 clk = ~clk;

    uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_a),
        .i_frame_start(frame_start), .i_sample_valid(sample_valid),
        .i_sampled_bit(sampled_bit), .i_par_en(par_en), .i_par_type(par_type),
        .o_data(data_a), .o_data_valid(valid_a), .o_parity_err(perr_a),
        .o_stop_err(serr_a), .o_start_err(start_err_a), .o_busy(busy_a)
    );

    uart_rx_frame_check #(.DATA_WIDTH(7), .STOP_BITS(2)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_b),
        .i_frame_start(frame_start), .i_sample_valid(sample_valid),
        .i_sampled_bit(sampled_bit), .i_par_en(par_en), .i_par_type(par_type),
        .o_data(data_b), .o_data_valid(valid_b), .o_parity_err(perr_b),
        .o_stop_err(serr_b), .o_start_err(start_err_b), .o_busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] o_data(input int sel);
        return (sel == 0) ? 32'(data_a) : 32'(data_b);
    endfunction
    function automatic logic o_valid(input int sel);
        return (sel == 0) ? valid_a : valid_b;
    endfunction
    function automatic logic o_perr(input int sel);
        return (sel == 0) ? perr_a : perr_b;
    endfunction
    function automatic logic o_serr(input int sel);
        return (sel == 0) ? serr_a : serr_b;
    endfunction
    function automatic logic o_serr_start(input int sel);
        return (sel == 0) ? start_err_a : start_err_b;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    // Check every output of one instance against the held expectation
    task automatic check_held(input int sel, input string tag);
        check({tag, "_data"},  o_data(sel),       32'(exp_data[sel]));
        check({tag, "_perr"},  32'(o_perr(sel)),  32'(exp_perr[sel]));
        check({tag, "_serr"},  32'(o_serr(sel)),  32'(exp_serr[sel]));
        check({tag, "_valid"}, 32'(o_valid(sel)), 32'd0);
        check({tag, "_sterr"}, 32'(o_serr_start(sel)), 32'd0);
        check({tag, "_busy"},  32'(o_busy(sel)),  32'd0);
    endtask

    // Send one frame to instance sel. abort_after >= 0 sends only that many
    // samples and then drops i_enable.
    task automatic send_frame(input int sel, input logic [8:0] d, input logic pe,
                              input logic pt, input logic pbit, input logic [1:0] stops,
                              input logic sbit, input int abort_after, input string tag);
        int         dw, sb, n, ones;
        logic       bits [$];
        logic [8:0] want;
        logic       e_perr, e_serr, spurious;

        dw = (sel == 0) ? 8 : 7;
        sb = (sel == 0) ? 1 : 2;
        bits.push_back(sbit);
        for (int i = 0; i < dw; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        for (int i = 0; i < sb; i++) bits.push_back(stops[i]);

        want   = d & 9'((1 << dw) - 1);
        ones   = $countones(want) + int'(pbit);
        e_perr = pe && (pt ? (ones % 2 == 0) : (ones % 2 == 1));
        e_serr = 1'b0;
        for (int i = 0; i < sb; i++) if (!stops[i]) e_serr = 1'b1;

        if (sbit)                  n = 1;
        else if (abort_after >= 0) n = abort_after;
        else                       n = bits.size();

        @(negedge clk);
        en_a         = (sel == 0);
        en_b         = (sel == 1);
        par_en       = pe;
        par_type     = pt;
        frame_start  = 1'b1;
        // A sample coinciding with the start pulse must be ignored
        sample_valid = ($urandom_range(0, 2) == 0);
        sampled_bit  = 1'($urandom);
        @(negedge clk);
        frame_start  = 1'b0;
        sample_valid = 1'b0;
        par_en       = 1'($urandom);
        par_type     = 1'($urandom);
        check({tag, "_busy_rise"}, 32'(o_busy(sel)), 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);

        spurious = 1'b0;
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sampled_bit  = bits[i];
            @(negedge clk);
            sample_valid = 1'b0;
            if (i != n - 1) begin
                spurious |= o_valid(sel) | o_serr_start(sel);
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    spurious |= o_valid(sel) | o_serr_start(sel);
                end
            end
        end
        check({tag, "_no_early_pulse"}, 32'(spurious), 32'd0);

        if (sbit) begin
            check({tag, "_sterr"}, 32'(o_serr_start(sel)), 32'd1);
            check({tag, "_busy"},  32'(o_busy(sel)),  32'd0);
            check({tag, "_valid"}, 32'(o_valid(sel)), 32'd0);
            check({tag, "_data"},  o_data(sel),       32'(exp_data[sel]));
            @(negedge clk);
            check({tag, "_sterr_1cyc"}, 32'(o_serr_start(sel)), 32'd0);
        end else if (abort_after >= 0) begin
            en_a = 1'b0;
            en_b = 1'b0;
            @(negedge clk);
            check_held(sel, {tag, "_abort"});
        end else begin
            exp_data[sel] = want;
            exp_perr[sel] = e_perr;
            exp_serr[sel] = e_serr;
            check({tag, "_valid"}, 32'(o_valid(sel)), 32'd1);
            check({tag, "_data"},  o_data(sel),       32'(want));
            check({tag, "_perr"},  32'(o_perr(sel)),  32'(e_perr));
            check({tag, "_serr"},  32'(o_serr(sel)),  32'(e_serr));
            check({tag, "_busy"},  32'(o_busy(sel)),  32'd0);
            check({tag, "_sterr"}, 32'(o_serr_start(sel)), 32'd0);
            @(negedge clk);
            check({tag, "_valid_1cyc"}, 32'(o_valid(sel)), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        frame_start = 1'b0; sample_valid = 1'b0; sampled_bit = 1'b1;
        par_en = 1'b0; par_type = 1'b0;
        for (int s = 0; s < 2; s++) begin
            exp_data[s] = '0; exp_perr[s] = 1'b0; exp_serr[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_held(0, "reset_a");
        check_held(1, "reset_b");
        rst_n = 1'b1;

        // Directed frames
        send_frame(0, 9'h55, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, -1, "8n1_55");
        send_frame(0, 9'h33, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, -1, "glitch");
        send_frame(0, 9'hA5, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, -1, "8e1_a5_ok");
        send_frame(0, 9'hA5, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, -1, "8e1_a5_bad");
        send_frame(0, 9'h01, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, -1, "8o1_01_ok");
        send_frame(0, 9'h01, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, -1, "8o1_01_stop0");
        send_frame(1, 9'h3C, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, -1, "7n2_3c_stop2");
        send_frame(1, 9'h3C, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, -1, "7n2_3c_clean");
        send_frame(0, 9'h7E, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 5,  "abort");
        send_frame(0, 9'h81, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, -1, "after_abort_81");

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            int         sel;
            logic [1:0] stops;
            sel      = int'($urandom_range(0, 1));
            stops[0] = ($urandom_range(0, 4) != 0);
            stops[1] = ($urandom_range(0, 4) != 0);
            send_frame(sel, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       stops, ($urandom_range(0, 9) == 0), -1, $sformatf("rnd%0d", k));
        end

        // Asynchronous reset in the middle of a frame
        send_frame(0, 9'h5A, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, -1, "pre_reset_5a");
        @(negedge clk);
        en_a = 1'b1; en_b = 1'b0; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; sample_valid = 1'b1; sampled_bit = 1'b0;
        @(negedge clk);
        sampled_bit = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            exp_data[s] = '0; exp_perr[s] = 1'b0; exp_serr[s] = 1'b0;
        end
        check_held(0, "midreset_a");
        check_held(1, "midreset_b");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(0, 9'hC3, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, -1, "post_reset_c3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
